// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-detected UART rx byte FIFO with sticky flags; irq built only under UART_RX_FIFO_IRQ_EN
module uart_rx_fifo #(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 8,
   parameter int IRQ_THRESH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           rx_data,
   input  logic                       rx_done,
   input  logic                       rx_err,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic                       overrun,
   output logic                       frame_err,
   input  logic                       clr_flags,
   input  logic                       flush,
   output logic                       irq
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
   logic done_q, err_q, push, ferr, pop, wr_en, ovr_next, ferr_next;
   assign level    = wr_ptr - rd_ptr;
   assign empty    = level == '0;
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_valid = ~empty;
   assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   always_comb begin
      push      = rx_done & ~done_q;
      ferr      = rx_err & ~err_q;
      pop       = rd_ready & ~empty;
      wr_en     = push & (~full | pop) & ~flush;
      wr_next   = flush ? '0 : wr_ptr + {{AW{1'b0}}, wr_en};
      rd_next   = flush ? '0 : rd_ptr + {{AW{1'b0}}, pop};
      ovr_next  = (push & full & ~pop & ~flush) | (overrun & ~clr_flags);
      ferr_next = ferr | (frame_err & ~clr_flags);
   end
   // edge registers reset high so a level already asserted at release is not an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         done_q    <= 1'b1;
         err_q     <= 1'b1;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         done_q    <= rx_done;
         err_q     <= rx_err;
         overrun   <= ovr_next;
         frame_err <= ferr_next;
      end
   end
   always_ff @(posedge clk)
      if (rst_n && wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
`ifdef UART_RX_FIFO_IRQ_EN
   localparam logic [AW:0] THR = IRQ_THRESH[AW:0];
   logic [AW:0] level_next;
   assign level_next = wr_next - rd_next;
   always_ff @(posedge clk) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= (level_next >= THR) | ovr_next | ferr_next;
   end
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   logic rst_n, rx_done, rx_err, rd_ready, clr_flags, flush;
   logic [7:0] rx_data, rd_data;
   logic rd_valid, full, empty, overrun, frame_err, irq;
   logic [4:0] level;
   int n_tests = 0;
   int n_fail = 0;
   uart_rx_fifo #(.DEPTH(16), .WIDTH(8), .IRQ_THRESH(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
      .full(full), .empty(empty), .overrun(overrun), .frame_err(frame_err),
      .clr_flags(clr_flags), .flush(flush), .irq(irq)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
   endtask
   logic exp_irq_on;
   initial begin
`ifdef UART_RX_FIFO_IRQ_EN
      exp_irq_on = 1'b1;
`else
      exp_irq_on = 1'b0;
`endif
      rst_n = 1'b0; rx_done = 1'b1; rx_err = 1'b0; rd_ready = 1'b0;
      clr_flags = 1'b0; flush = 1'b0; rx_data = 8'h00;
      tick(); tick();
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_valid", rd_valid, 0);
      check("rst_full", full, 0);
      check("rst_data", rd_data, 0);
      check("rst_ovr", overrun, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_irq", irq, 0);
      rst_n = 1'b1;
      tick(); tick();
      check("held_done_no_push", level, 0);
      rx_done = 1'b0;
      tick();
      check("done_fall_no_push", level, 0);
      // byte with done held 4 clocks
      rx_data = 8'hA5; rx_done = 1'b1;
      tick();
      check("push_latency", rd_valid, 1);
      tick(); tick(); tick();
      check("held_one_byte", level, 1);
      rx_done = 1'b0;
      tick();
      push_byte(8'h3C);
      check("two_level", level, 2);
      check("head_a5", rd_data, 8'hA5);
      rd_ready = 1'b1;
      tick();
      check("head_3c", rd_data, 8'h3C);
      tick();
      check("drained_empty", empty, 1);
      check("drained_data0", rd_data, 0);
      tick();
      check("pop_empty_ignored", level, 0);
      rd_ready = 1'b0;
      // overfill
      for (int i = 0; i < 17; i++) push_byte(8'(i));
      check("fill_full", full, 1);
      check("fill_level", level, 16);
      check("fill_ovr", overrun, 1);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("order_%0d", i), rd_data, i);
         tick();
      end
      rd_ready = 1'b0;
      check("after_order_empty", empty, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("ovr_cleared", overrun, 0);
      // push+pop while full
      for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
      rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
      tick();
      rx_done = 1'b0; rd_ready = 1'b0;
      check("pp_full_level", level, 16);
      check("pp_full_ovr", overrun, 0);
      rd_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check($sformatf("pp_order_%0d", i), rd_data, 8'h20 + i);
         tick();
      end
      check("pp_last_77", rd_data, 8'h77);
      tick();
      rd_ready = 1'b0;
      check("pp_empty", empty, 1);
      // flush with same-cycle push
      for (int i = 0; i < 3; i++) push_byte(8'(8'h40 + i));
      check("pre_flush_level", level, 3);
      rx_data = 8'h99; rx_done = 1'b1; flush = 1'b1;
      tick();
      rx_done = 1'b0; flush = 1'b0;
      check("flush_level", level, 0);
      check("flush_ovr", overrun, 0);
      tick();
      check("flush_push_lost", level, 0);
      // framing errors
      rx_err = 1'b1;
      tick();
      check("ferr_set", frame_err, 1);
      check("ferr_no_entry", level, 0);
      rx_err = 1'b0;
      tick();
      clr_flags = 1'b1; rx_err = 1'b1;
      tick();
      check("ferr_set_wins", frame_err, 1);
      rx_err = 1'b0;
      tick();
      clr_flags = 1'b0;
      check("ferr_cleared", frame_err, 0);
      push_byte(8'h5A);
      check("post_ferr_data", rd_data, 8'h5A);
      // reset mid-transfer
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_level", level, 0);
      check("midrst_data", rd_data, 0);
      tick();
      // irq threshold
      for (int i = 0; i < 7; i++) push_byte(8'(i));
      check("irq_7", irq, 0);
      rx_data = 8'h07; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check("irq_8", irq, exp_irq_on);
      tick();
      check("irq_8_hold", irq, exp_irq_on);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("irq_pop_level", level, 7);
      check("irq_pop", irq, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
